// File: rtl/run_sequencer.sv
// run_sequencer: launches NPROG programs through the Start/Done handshake and reports each run length.
module run_sequencer #(
    parameter int NPROG   = 3,
    parameter int HOLD    = 4,
    parameter int CW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Done,
    output logic          Start,
    output logic [1:0]    ProgIdx,
    output logic [CW-1:0] CycleCount,
    output logic          CountValid,
    output logic          TimedOut,
    output logic          Busy,
    output logic          AllDone
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [1:0]    LAST      = 2'(NPROG - 1);
    localparam logic [CW-1:0] TMO       = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ASSERT, RUN, REPORT, FINISH} state_t;

    state_t        state_q;
    logic [HW-1:0] hold_q;
    logic [CW-1:0] run_q, run_d;
    logic          start_q, count_valid_q, timed_out_q, busy_q, all_done_q;
    logic [1:0]    prog_q;
    logic [CW-1:0] cycle_count_q;

    // run_q holds completed RUN cycles, so run_d is the number of the current one
    assign run_d = run_q + CW'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            run_q         <= '0;
            start_q       <= 1'b0;
            prog_q        <= '0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            timed_out_q   <= 1'b0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                IDLE, FINISH: begin
                    if (Go) begin
                        state_q     <= ASSERT;
                        start_q     <= 1'b1;
                        prog_q      <= '0;
                        timed_out_q <= 1'b0;
                        hold_q      <= '0;
                        busy_q      <= 1'b1;
                        all_done_q  <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= RUN;
                        start_q <= 1'b0;
                        run_q   <= '0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                RUN: begin
                    // Done beats a coinciding timeout
                    if (Done || run_d == TMO) begin
                        state_q       <= REPORT;
                        cycle_count_q <= run_d;
                        count_valid_q <= 1'b1;
                        timed_out_q   <= !Done;
                    end else begin
                        run_q <= run_d;
                    end
                end
                REPORT: begin
                    if (!timed_out_q && prog_q < LAST) begin
                        state_q <= ASSERT;
                        prog_q  <= prog_q + 2'd1;
                        start_q <= 1'b1;
                        hold_q  <= '0;
                    end else begin
                        state_q    <= FINISH;
                        busy_q     <= 1'b0;
                        all_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Start      = start_q;
    assign ProgIdx    = prog_q;
    assign CycleCount = cycle_count_q;
    assign CountValid = count_valid_q;
    assign TimedOut   = timed_out_q;
    assign Busy       = busy_q;
    assign AllDone    = all_done_q;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer (3-program and 1-program instances, TIMEOUT=20).
module tb_run_sequencer;
    localparam int HOLD = 4;
    localparam int TMO  = 20;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, a_go, a_done, b_go, b_done;
    logic        a_start, a_cv, a_to, a_busy, a_all;
    logic        b_start, b_cv, b_to, b_busy, b_all;
    logic [1:0]  a_idx, b_idx;
    logic [15:0] a_cnt, b_cnt;
    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    run_sequencer #(.NPROG(3), .HOLD(HOLD), .CW(16), .TIMEOUT(TMO)) dut_a (
        .Clk(clk), .Reset(rst), .Go(a_go), .Done(a_done), .Start(a_start), .ProgIdx(a_idx),
        .CycleCount(a_cnt), .CountValid(a_cv), .TimedOut(a_to), .Busy(a_busy), .AllDone(a_all)
    );

    run_sequencer #(.NPROG(1), .HOLD(HOLD), .CW(16), .TIMEOUT(TMO)) dut_b (
        .Clk(clk), .Reset(rst), .Go(b_go), .Done(b_done), .Start(b_start), .ProgIdx(b_idx),
        .CycleCount(b_cnt), .CountValid(b_cv), .TimedOut(b_to), .Busy(b_busy), .AllDone(b_all)
    );

    // every CountValid pulse of dut_a must match the oldest expected report
    always @(negedge clk) begin
        if (a_cv === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: idx=%0d cnt=%0d to=%0b, nothing expected", a_idx, a_cnt, a_to);
            end else begin
                mon_e = sb.pop_front();
                if ({a_idx, a_cnt, a_to} !== {mon_e.idx, mon_e.cnt, mon_e.to}) begin
                    fails++;
                    $display("FAIL sb_report: got idx=%0d cnt=%0d to=%0b, want idx=%0d cnt=%0d to=%0b",
                             a_idx, a_cnt, a_to, mon_e.idx, mon_e.cnt, mon_e.to);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; a_go = 1'b0; a_done = 1'b0; b_go = 1'b0; b_done = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic go_a();
        a_go = 1'b1;
        cyc();
        a_go = 1'b0;
    endtask

    // Starts in the first ASSERT cycle, ends in the REPORT cycle.
    task automatic run_prog(input int idx, input int k, input logic to, output int hi);
        exp_t e;
        hi = 0;
        repeat (HOLD) begin
            if (a_start === 1'b1) hi++;
            cyc();
        end
        for (int j = 1; j < k; j++) cyc();
        a_done = 1'b1;
        e.idx = 2'(idx); e.cnt = 16'(k); e.to = to;
        sb.push_back(e);
        cyc();
        a_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_go = 1'b1; a_done = 1'b1; b_go = 1'b1; b_done = 1'b1;
        repeat (3) begin
            cyc();
            tests++;
            if ({a_start, a_idx, a_cnt, a_cv, a_to, a_busy, a_all, b_start, b_cv, b_busy, b_all} !== '0) begin
                fails++;
                $display("FAIL reset_outputs: a start=%b idx=%0d cnt=%0d cv=%b to=%b busy=%b all=%b, want all 0",
                         a_start, a_idx, a_cnt, a_cv, a_to, a_busy, a_all);
            end
        end
        rst = 1'b0; a_done = 1'b0; b_done = 1'b0;
        cyc();
        tests++;
        if ({a_start, a_idx, a_busy} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_go_after: start=%b idx=%0d busy=%b, want start=1 idx=0 busy=1", a_start, a_idx, a_busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        int hi = 0;
        b_go = 1'b1;
        cyc();
        b_go = 1'b0;
        repeat (HOLD) begin
            if (b_start === 1'b1) hi++;
            cyc();
        end
        tests++;
        if (hi != HOLD || b_start !== 1'b0) begin
            fails++;
            $display("FAIL single_hold: start high %0d cycles, start now %b, want %0d and 0", hi, b_start, HOLD);
        end
        repeat (9) cyc();
        b_done = 1'b1;
        cyc();
        b_done = 1'b0;
        tests++;
        if ({b_cv, b_cnt, b_idx, b_to} !== {1'b1, 16'd10, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL single_report: cv=%b cnt=%0d idx=%0d to=%b, want cv=1 cnt=10 idx=0 to=0", b_cv, b_cnt, b_idx, b_to);
        end
        cyc();
        tests++;
        if ({b_all, b_busy, b_cv, b_start} !== 4'b1000) begin
            fails++;
            $display("FAIL single_finish: all=%b busy=%b cv=%b start=%b, want 1 0 0 0", b_all, b_busy, b_cv, b_start);
        end
        do_reset();
    endtask

    task automatic test_three();
        int ks[3] = '{5, 12, 1};
        int hi;
        go_a();
        for (int p = 0; p < 3; p++) begin
            run_prog(p, ks[p], 1'b0, hi);
            tests++;
            if (hi != HOLD || a_start !== 1'b0) begin
                fails++;
                $display("FAIL three_hold p%0d: start high %0d cycles, start in report %b, want %0d and 0", p, hi, a_start, HOLD);
            end
            cyc();
            if (p < 2) begin
                tests++;
                if ({a_start, a_idx} !== {1'b1, 2'(p + 1)}) begin
                    fails++;
                    $display("FAIL three_next p%0d: start=%b idx=%0d, want start=1 idx=%0d", p, a_start, a_idx, p + 1);
                end
            end
        end
        tests++;
        if ({a_all, a_busy, a_to, a_idx, a_cnt} !== {1'b1, 1'b0, 1'b0, 2'd2, 16'd1}) begin
            fails++;
            $display("FAIL three_finish: all=%b busy=%b to=%b idx=%0d cnt=%0d, want 1 0 0 2 1", a_all, a_busy, a_to, a_idx, a_cnt);
        end
        do_reset();
    endtask

    task automatic test_done_early();
        exp_t e;
        a_done = 1'b1;
        go_a();
        repeat (HOLD) cyc();
        e.idx = 2'd0; e.cnt = 16'd1; e.to = 1'b0;
        sb.push_back(e);
        cyc();
        a_done = 1'b0;
        tests++;
        if ({a_cv, a_cnt} !== {1'b1, 16'd1}) begin
            fails++;
            $display("FAIL done_early: cv=%b cnt=%0d, want cv=1 cnt=1", a_cv, a_cnt);
        end
        do_reset();
    endtask

    task automatic test_coincide();
        int hi;
        go_a();
        run_prog(0, TMO, 1'b0, hi);
        cyc();
        tests++;
        if ({a_start, a_idx, a_to} !== {1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL coincide: start=%b idx=%0d to=%b, want start=1 idx=1 to=0", a_start, a_idx, a_to);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   rose = 0;
        go_a();
        repeat (HOLD + TMO - 1) cyc();
        e.idx = 2'd0; e.cnt = 16'(TMO); e.to = 1'b1;
        sb.push_back(e);
        cyc();
        repeat (3) begin
            cyc();
            if (a_start !== 1'b0) rose++;
        end
        tests++;
        if ({a_all, a_to, a_idx, a_cnt} !== {1'b1, 1'b1, 2'd0, 16'(TMO)} || rose != 0) begin
            fails++;
            $display("FAIL timeout_finish: all=%b to=%b idx=%0d cnt=%0d start_seen=%0d, want 1 1 0 %0d 0",
                     a_all, a_to, a_idx, a_cnt, rose, TMO);
        end
        go_a();
        tests++;
        if ({a_start, a_to, a_idx, a_all} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL timeout_restart: start=%b to=%b idx=%0d all=%b, want 1 0 0 0", a_start, a_to, a_idx, a_all);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int hi;
        go_a();
        run_prog(0, 3, 1'b0, hi);
        cyc();
        repeat (HOLD + 6) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tests++;
        if ({a_start, a_idx, a_cnt, a_cv, a_to, a_busy, a_all} !== '0) begin
            fails++;
            $display("FAIL reset_mid: start=%b idx=%0d cnt=%0d cv=%b to=%b busy=%b all=%b, want all 0",
                     a_start, a_idx, a_cnt, a_cv, a_to, a_busy, a_all);
        end
        cyc();
        tests++;
        if ({a_start, a_busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid_idle: start=%b busy=%b, want 0 0", a_start, a_busy);
        end
        go_a();
        run_prog(0, 4, 1'b0, hi);
        tests++;
        if ({a_idx, a_cnt} !== {2'd0, 16'd4}) begin
            fails++;
            $display("FAIL reset_mid_fresh: idx=%0d cnt=%0d, want 0 4", a_idx, a_cnt);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        b_go = 1'b1;
        repeat (HOLD + 1) cyc();
        b_done = 1'b1;
        cyc();
        b_done = 1'b0;
        cyc();
        tests++;
        if ({b_all, b_start} !== 2'b10) begin
            fails++;
            $display("FAIL b2b_finish: all=%b start=%b, want 1 0", b_all, b_start);
        end
        cyc();
        tests++;
        if ({b_all, b_start, b_busy} !== 3'b011) begin
            fails++;
            $display("FAIL b2b_relaunch: all=%b start=%b busy=%b, want 0 1 1", b_all, b_start, b_busy);
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1; a_go = 1'b0; a_done = 1'b0; b_go = 1'b0; b_done = 1'b0;
        test_reset();
        test_single();
        test_three();
        test_done_early();
        test_coincide();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        cyc();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d reports missing, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Harness-side initiator for the processor's Start/Done program-launch protocol. On a Go request, it drives Start for a fixed hold window for each of NPROG programs in order. It then measures the cycles until the processor raises Done and reports each count. It sits between the top-level testbench/board controller and the processor core, and is the counterpart of the program counter's Start-hold/release behaviour.

## Interface
- NPROG, 3, number of programs launched per sequence (1..4)
- HOLD, 4, cycles Start is held high per launch (>=1)
- CW, 16, CycleCount width
- TIMEOUT, 4096, max RUN cycles per program before abort (< 2^CW)
- Clk  in  1  single clock; all state changes on posedge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Go  in  1  request to launch the sequence; sampled only in IDLE or FINISH
- Done  in  1  processor completion flag; level, sampled only in RUN
- Start  out  1  launch strobe to processor
- ProgIdx  out  2  index of program currently launched/running/reported
- CycleCount  out  CW  measured cycles of the last completed program
- CountValid  out  1  one-cycle pulse: CycleCount/ProgIdx valid
- TimedOut  out  1  sticky: a program exceeded TIMEOUT
- Busy  out  1  high in ASSERT, RUN, REPORT
- AllDone  out  1  high in FINISH

## Operation
- States: IDLE, ASSERT, RUN, REPORT, FINISH.
- Reset (any state, any cycle): state=IDLE. All outputs are 0: Start, ProgIdx, CycleCount, CountValid, TimedOut, Busy, AllDone. Hold counter and run counter are cleared.
- IDLE:
  - Go=1 -> ASSERT with ProgIdx=0.
  - Done is ignored.
- ASSERT:
  - Start=1 for exactly HOLD consecutive cycles, then -> RUN.
  - Done is ignored, including if it is already high.
  - Go is ignored.
- RUN:
  - Start=0. The run counter increments each cycle; the first RUN cycle counts as 1.
  - Done=1 sampled in RUN cycle k -> REPORT with CycleCount=k.
  - If k reaches TIMEOUT with Done=0 -> TimedOut=1, CycleCount=TIMEOUT, then REPORT.
  - If Done and the timeout coincide on the same cycle, Done wins: TimedOut stays 0.
- REPORT (1 cycle):
  - CountValid=1; ProgIdx still names the reported program.
  - Next state is decided in this priority order:
    - TimedOut=1 -> FINISH (remaining programs are skipped).
    - ProgIdx<NPROG-1 -> ProgIdx+1, then ASSERT.
    - Otherwise -> FINISH.
- FINISH:
  - AllDone=1, Busy=0.
  - CycleCount, ProgIdx and TimedOut hold their values.
  - Go=1 -> clear TimedOut, ProgIdx=0, then ASSERT.
- Width rules:
  - The run counter is CW bits and never wraps, because it stops at TIMEOUT.
  - ProgIdx increments without modulo; NPROG<=4 guarantees it fits.
- Go is a level. Held high continuously, it causes exactly one sequence launch per IDLE/FINISH visit.

## Timing
- All outputs are registered; none depend combinationally on Go or Done.
- Go=1 at edge t in IDLE: Start=1 during cycles t+1..t+HOLD, and the first RUN cycle is t+HOLD+1.
- Done sampled at the edge ending RUN cycle k: CountValid=1 during the next cycle.
  - The next program's Start rises the cycle after that.
  - Gap from Done to the next Start = 2 cycles.
- Per-program latency (Go or previous REPORT to CountValid) = HOLD + k + 1 cycles.
- Reset asserted at edge t: all outputs are 0 from cycle t+1. No Start glitch; Start drops in the same cycle.
- Reset takes priority over Go at the same edge.

## Test plan
- Reset values: hold Reset 3 cycles with Go=1 and Done=1 -> all outputs 0 and state IDLE during and after Reset; Go is honoured only after Reset falls.
- Single program (NPROG=1, HOLD=4): Go pulse at cycle 0, Done rises in RUN cycle 10 -> Start high in cycles 1..4; CountValid=1 with CycleCount=10 and ProgIdx=0; AllDone=1 the next cycle.
- Three programs with Done at RUN cycles 5, 12, 1 -> three CountValid pulses with (ProgIdx,CycleCount) = (0,5), (1,12), (2,1); Start rises 2 cycles after each Done; then AllDone=1 and TimedOut=0.
- Done held high throughout ASSERT -> ignored; the count reflects the first RUN cycle, so CycleCount=1.
- Timeout (TIMEOUT=20): Done never asserted on program 0 -> CountValid with CycleCount=20 and TimedOut=1; FINISH with program 1 never started. A new Go clears TimedOut and restarts at ProgIdx=0.
- Reset mid-RUN of program 1 at RUN cycle 7 -> next cycle all outputs 0 and state IDLE; a later Go restarts at program 0 with a fresh count.
